// File: rtl/demux_pkg.sv
// demux_pkg: shared state type and Demux geometry for the serial driver
package demux_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} drv_state_t;

    localparam int DEMUX_SEL_W    = 2;
    localparam int DEMUX_CHANNELS = 4;

endpackage

// File: rtl/demux_piso_shreg.sv
// demux_piso_shreg: parallel-load shift register presenting one bit per shift
module demux_piso_shreg #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit_o
);

    logic [DATA_W-1:0] sh_q, sh_d;

    // load wins over shift; zero fill drains the word so the output idles low after a frame
    always_comb sh_d = load_i ? data_i : shift_i ? (LSB_FIRST ? sh_q >> 1 : sh_q << 1) : sh_q;

    // shift register state
    always_ff @(posedge clk)
        if (rst) sh_q <= '0;
        else     sh_q <= sh_d;

    assign bit_o = LSB_FIRST ? sh_q[0] : sh_q[DATA_W-1];

endmodule

// File: rtl/demux_serial_driver.sv
// demux_serial_driver: serialises a word onto Demux D while holding S at the chosen channel
module demux_serial_driver
    import demux_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SEL_W      = DEMUX_SEL_W,
    parameter int GAP_CYCLES = 1,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_chan,
    output logic              D,
    output logic [SEL_W-1:0]  S,
    output logic              bit_strobe,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    drv_state_t    state_q;
    logic [BW-1:0] bit_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic          accept;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // D comes straight from a flop in the shift register, so it is registered and idles at 0
    demux_piso_shreg #(
        .DATA_W   (DATA_W),
        .LSB_FIRST(LSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .shift_i(state_q == SHIFT),
        .data_i (in_data),
        .bit_o  (D)
    );

    // frame sequencer: IDLE -> SHIFT -> GAP -> IDLE with registered S/strobe/busy/done
    always_ff @(posedge clk)
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            S          <= '0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE:
                    if (accept) begin
                        state_q    <= SHIFT;
                        S          <= in_chan;
                        bit_strobe <= 1'b1;
                        busy       <= 1'b1;
                    end
                SHIFT:
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q    <= (GAP_CYCLES > 0) ? GAP : IDLE;
                        busy       <= GAP_CYCLES > 0;
                        bit_strobe <= 1'b0;
                        frame_done <= 1'b1;
                        bit_cnt_q  <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                GAP:
                    if (gap_cnt_q == LAST_GAP) begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                default: state_q <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_demux_serial_driver.sv
// tb_demux_serial_driver: directed and random frames checked against a frame-level reference
module tb_demux_serial_driver;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [1:0] in_chan = '0;
    logic       in_ready, D, bit_strobe, busy, frame_done;
    logic [1:0] S;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = -1;
    int prev_acc = -1;

    always #5 clk = ~clk;

    demux_serial_driver dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chan   (in_chan),
        .D         (D),
        .S         (S),
        .bit_strobe(bit_strobe),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // timestamps of accepted words, used to check the frame-to-frame spacing
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            prev_acc <= last_acc;
            last_acc <= cyc;
        end
    end

    function automatic logic [6:0] pk(logic d, logic st, logic b, logic r, logic f, logic [1:0] s);
        return {d, st, b, r, f, s};
    endfunction

    function automatic logic [6:0] obs();
        return pk(D, bit_strobe, busy, in_ready, frame_done, S);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, o, e);
        end
    endtask

    // Offer word d for channel c; while busy, offer (jv, jd, jc), which must be ignored.
    // abort_at > 0 asserts rst after that many data bits have been checked.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] c, input bit jv,
                             input logic [7:0] jd, input logic [1:0] jc, input int abort_at);
        logic [3:0] y_or;
        y_or     = '0;
        in_valid = 1'b1;
        in_data  = d;
        in_chan  = c;
        chk("ready_idle", in_ready, 1);
        @(negedge clk);
        for (int k = 0; k < W; k++) begin
            chk($sformatf("bit%0d_d%02h_c%0d", k, d, c), obs(), pk(d[k], 1'b1, 1'b1, 1'b0, 1'b0, c));
            y_or = y_or | (4'(D) << S);
            in_valid = jv;
            in_data  = jd;
            in_chan  = jc;
            if (k + 1 == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_outputs", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
                rst      = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("abort_ready", {in_ready, frame_done}, 2'b10);
                @(negedge clk);
                chk("abort_no_done", {frame_done, busy, D}, 3'b000);
                return;
            end
            @(negedge clk);
        end
        chk($sformatf("demux_y_c%0d", c), y_or, (d != 8'h00) ? (4'b0001 << c) : 4'b0000);
        chk("frame_done", obs(), pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, c));
        @(negedge clk);
        chk("back_idle", obs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c));
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        rst = 1'b0;
        #1;
        chk("reset_ready", in_ready, 1);

        run_frame(8'hA5, 2'b10, 1'b0, 8'h00, 2'b00, 0);

        run_frame(8'h3C, 2'b01, 1'b1, 8'hC3, 2'b11, 0);
        run_frame(8'hC3, 2'b11, 1'b0, 8'h00, 2'b00, 0);
        chk("accept_spacing", 32'(last_acc - prev_acc), 32'd10);

        run_frame(8'hFF, 2'b01, 1'b0, 8'h00, 2'b00, 3);
        run_frame(8'h01, 2'b01, 1'b0, 8'h00, 2'b00, 0);

        for (int c = 0; c < 4; c++) run_frame(8'hFF, 2'(c), 1'b0, 8'h00, 2'b00, 0);

        run_frame(8'hFF, 2'b10, 1'b1, 8'h00, 2'b01, 0);

        repeat (20) run_frame(8'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 2'($urandom), 0);

        repeat (3) @(negedge clk);
        chk("final_idle", obs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
